// File: rtl/bulk_read_arbiter_n_pkg.sv
// rtl/bulk_read_arbiter_n_pkg.sv - shared types and round-robin helper for the bulk port arbiter
package bulk_mem_pkg;

    // Upper bound on requesters; req_id_t is sized from it so every user agrees on ID width.
    localparam int MAX_REQ        = 16;
    localparam int ID_W           = $clog2(MAX_REQ);
    localparam int BULK_DATA_W    = 64;
    localparam int BULK_LINE_SIZE = 8;

    typedef logic [ID_W-1:0]                          req_id_t;
    typedef logic [BULK_LINE_SIZE*BULK_DATA_W-1:0]    line_t;
    typedef logic [BULK_LINE_SIZE*BULK_DATA_W/8-1:0]  strb_t;

    typedef struct packed {
        logic    found;
        req_id_t id;
    } rr_pick_t;

    // First set bit of valid at or after ptr, wrapping within the num active requesters.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input req_id_t            ptr,
                                         input int                 num);
        rr_pick_t r;
        int       idx;
        r = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < num) begin
                idx = (int'(ptr) + k) % num;
                if (valid[idx[ID_W-1:0]]) begin
                    r.found = 1'b1;
                    r.id    = req_id_t'(idx);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bulk_read_arbiter_n_if.sv
// rtl/bulk_read_arbiter_n_if.sv - requester and memory-side signal bundle for the bulk port arbiter
interface bulk_read_arbiter_n_if #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int LINE_SIZE = 8
);
    localparam int LINE_W = LINE_SIZE * DATA_W;
    localparam int STRB_W = LINE_W / 8;

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             req_lock;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]             req_write;
    logic [NUM_REQ-1:0][LINE_W-1:0] req_wdata;
    logic [NUM_REQ-1:0][STRB_W-1:0] req_wstrb;
    logic [NUM_REQ-1:0]             resp_valid;
    logic [LINE_W-1:0]              resp_rdata;

    logic                           mem_req_valid;
    logic                           mem_req_ready;
    logic [ADDR_W-1:0]              mem_req_addr;
    logic                           mem_req_write;
    logic [LINE_W-1:0]              mem_req_wdata;
    logic [STRB_W-1:0]              mem_req_wstrb;
    logic                           mem_resp_valid;
    logic [LINE_W-1:0]              mem_resp_rdata;

    // Arbiter view
    modport slave (
        input  req_valid, req_lock, req_addr, req_write, req_wdata, req_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
        output req_ready, resp_valid, resp_rdata,
        output mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata, mem_req_wstrb
    );

    // Requester / memory-controller view
    modport master (
        output req_valid, req_lock, req_addr, req_write, req_wdata, req_wstrb,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata,
        input  req_ready, resp_valid, resp_rdata,
        input  mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata, mem_req_wstrb
    );

endinterface

// File: rtl/bulk_read_arbiter_n_id_fifo.sv
// rtl/bulk_read_arbiter_n_id_fifo.sv - synchronous FIFO of owner IDs for in-order response routing
module bulk_id_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= bump(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= bump(rd_ptr_q);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/bulk_read_arbiter_n.sv
// rtl/bulk_read_arbiter_n.sv - round-robin N-requester bulk port arbiter with lock; BULK_ARB_STATS_EN adds counters
module bulk_read_arbiter_n
    import bulk_mem_pkg::*;
#(
    parameter int DATA_W          = 64,
    parameter int ADDR_W          = 64,
    parameter int LINE_SIZE       = 8,
    parameter int NUM_REQ         = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    bulk_read_arbiter_n_if.slave     bus,
    output logic                     orphan_resp_o
`ifdef BULK_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][31:0] grant_count_o,
    output logic [31:0]              lock_cycles_o
`endif
);
    localparam int LINE_W = LINE_SIZE * DATA_W;
    localparam int STRB_W = LINE_W / 8;

    req_id_t              rr_ptr_q, rr_ptr_d;
    logic                 orphan_q, orphan_d;
    logic                 any_lock;
    req_id_t              lock_id;
    logic [MAX_REQ-1:0]   cand;
    rr_pick_t             pick;
    logic                 grant_ok;
    logic                 accept;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    req_id_t              fifo_head;
    logic [ADDR_W-1:0]    addr_mux;
    logic                 write_mux;
    logic [LINE_W-1:0]    wdata_mux;
    logic [STRB_W-1:0]    wstrb_mux;

    // Lock narrows eligibility to the highest-index locked requester; its valid still gates.
    always_comb begin
        any_lock = 1'b0;
        lock_id  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_lock[i]) begin
                any_lock = 1'b1;
                lock_id  = req_id_t'(i);
            end
        end
        cand = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand[i] = bus.req_valid[i] && (!any_lock || lock_id == req_id_t'(i));
        end
        pick = rr_pick(cand, rr_ptr_q, NUM_REQ);
    end

    // A full ID FIFO blocks issue even if a response pops it this cycle.
    assign grant_ok = pick.found && !fifo_full && !rst;
    assign accept   = grant_ok && bus.mem_req_ready;
    assign pop      = !rst && bus.mem_resp_valid && !fifo_empty;

    always_comb begin
        addr_mux      = '0;
        write_mux     = 1'b0;
        wdata_mux     = '0;
        wstrb_mux     = '0;
        bus.req_ready = '0;
        bus.resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick.found && pick.id == req_id_t'(i)) begin
                addr_mux          = bus.req_addr[i];
                write_mux         = bus.req_write[i];
                wdata_mux         = bus.req_wdata[i];
                wstrb_mux         = bus.req_wstrb[i];
                bus.req_ready[i]  = accept;
            end
            bus.resp_valid[i] = pop && (fifo_head == req_id_t'(i));
        end
    end

    assign bus.mem_req_valid = grant_ok;
    assign bus.mem_req_addr  = addr_mux;
    assign bus.mem_req_write = write_mux;
    assign bus.mem_req_wdata = wdata_mux;
    assign bus.mem_req_wstrb = wstrb_mux;
    assign bus.resp_rdata    = bus.mem_resp_rdata;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (pick.id == req_id_t'(NUM_REQ - 1)) ? '0 : pick.id + req_id_t'(1);
        end
        orphan_d = orphan_q || (bus.mem_resp_valid && fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            orphan_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            orphan_q <= orphan_d;
        end
    end

    assign orphan_resp_o = orphan_q;

    bulk_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .data_i  (pick.id),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

`ifdef BULK_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] grant_count_q;
    logic [31:0]              lock_cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_count_q <= '0;
            lock_cycles_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept && pick.id == req_id_t'(i) && grant_count_q[i] != '1) begin
                    grant_count_q[i] <= grant_count_q[i] + 32'd1;
                end
            end
            if (any_lock && lock_cycles_q != '1) begin
                lock_cycles_q <= lock_cycles_q + 32'd1;
            end
        end
    end

    assign grant_count_o = grant_count_q;
    assign lock_cycles_o = lock_cycles_q;
`endif

endmodule

// File: tb/tb_bulk_read_arbiter_n.sv
// tb/tb_bulk_read_arbiter_n.sv - table-driven self-checking bench for bulk_read_arbiter_n
module tb_bulk_read_arbiter_n;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int LINE_SZ = 8;
    localparam int LINE_W  = LINE_SZ * DATA_W;
    localparam int STRB_W  = LINE_W / 8;

    logic clk = 1'b0;
    logic rst;
    logic orphan_resp;
`ifdef BULK_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] grant_count;
    logic [31:0]              lock_cycles;
`endif

    always #5 clk = ~clk;

    bulk_read_arbiter_n_if #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_SIZE(LINE_SZ)
    ) bus ();

    bulk_read_arbiter_n #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_SIZE(LINE_SZ),
        .NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .orphan_resp_o (orphan_resp)
`ifdef BULK_ARB_STATS_EN
        ,
        .grant_count_o (grant_count),
        .lock_cycles_o (lock_cycles)
`endif
    );

    typedef struct {
        logic       rst;
        logic [2:0] valid;
        logic [2:0] lock;
        logic       mrdy;
        logic       mresp;
        int         gnt;
        logic       mval;
    } vec_t;

    vec_t              vecs[$];
    int                exp_q[$];
    logic              exp_orphan;
    int                errors = 0;
    int                checks = 0;
    logic [ADDR_W-1:0] addr_tab  [NUM_REQ];
    logic [LINE_W-1:0] wdata_tab [NUM_REQ];
    logic [STRB_W-1:0] wstrb_tab [NUM_REQ];
    logic [2:0]        wr_tab = 3'b010;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [2:0] va, input logic [2:0] lk,
                       input logic mr, input logic ms, input int g, input logic mv);
        vec_t v;
        v.rst = r; v.valid = va; v.lock = lk; v.mrdy = mr; v.mresp = ms; v.gnt = g; v.mval = mv;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [2:0] va, input logic [2:0] lk,
                         input logic mr, input logic ms);
        rst                = r;
        bus.req_valid      = va;
        bus.req_lock       = lk;
        bus.mem_req_ready  = mr;
        bus.mem_resp_valid = ms;
        bus.mem_resp_rdata = {$urandom(), $urandom(), $urandom(), $urandom(),
                              $urandom(), $urandom(), $urandom(), $urandom(),
                              $urandom(), $urandom(), $urandom(), $urandom(),
                              $urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    initial begin
        logic [2:0]        exp_rdy, exp_resp;
        logic [ADDR_W-1:0] exp_addr;
        logic [LINE_W-1:0] exp_wdata;
        logic [STRB_W-1:0] exp_wstrb;
        logic              exp_write;
        vec_t              v;

        for (int i = 0; i < NUM_REQ; i++) begin
            addr_tab[i]  = 64'h1000 * (NUM_REQ - i);
            wdata_tab[i] = {16{$urandom()}};
            wstrb_tab[i] = {$urandom(), $urandom()};
            bus.req_addr[i]  = addr_tab[i];
            bus.req_wdata[i] = wdata_tab[i];
            bus.req_wstrb[i] = wstrb_tab[i];
        end
        bus.req_write = wr_tab;
        drive(1'b1, 3'b111, 3'b000, 1'b1, 1'b1);

        // Round robin with 2-cycle memory latency
        add(0, 3'b111, 3'b000, 1, 0, 0, 1);
        add(0, 3'b111, 3'b000, 1, 0, 1, 1);
        add(0, 3'b111, 3'b000, 1, 1, 2, 1);
        add(0, 3'b111, 3'b000, 1, 1, 0, 1);
        add(0, 3'b111, 3'b000, 1, 1, 1, 1);
        add(0, 3'b111, 3'b000, 1, 1, 2, 1);
        add(0, 3'b000, 3'b000, 1, 1, -1, 0);
        add(0, 3'b000, 3'b000, 1, 1, -1, 0);
        // Lock on requester 1, then release; then highest-index lock wins
        add(0, 3'b111, 3'b010, 1, 0, 1, 1);
        for (int i = 0; i < 4; i++) add(0, 3'b111, 3'b010, 1, 1, 1, 1);
        add(0, 3'b111, 3'b000, 1, 1, 2, 1);
        add(0, 3'b111, 3'b101, 1, 1, 2, 1);
        add(0, 3'b011, 3'b101, 1, 1, -1, 0);
        // Fill to MAX_OUTSTANDING, no same-cycle bypass on pop
        add(0, 3'b111, 3'b000, 1, 0, 0, 1);
        add(0, 3'b111, 3'b000, 1, 0, 1, 1);
        add(0, 3'b111, 3'b000, 1, 0, 2, 1);
        add(0, 3'b111, 3'b000, 1, 0, 0, 1);
        add(0, 3'b111, 3'b000, 1, 0, 1, 0);
        add(0, 3'b111, 3'b000, 1, 1, 1, 0);
        add(0, 3'b111, 3'b000, 1, 0, 1, 1);
        for (int i = 0; i < 4; i++) add(0, 3'b000, 3'b000, 1, 1, -1, 0);
        // Downstream stall on requester 2
        for (int i = 0; i < 3; i++) add(0, 3'b100, 3'b000, 0, 0, 2, 1);
        add(0, 3'b100, 3'b000, 1, 0, 2, 1);
        add(0, 3'b011, 3'b000, 1, 0, 0, 1);
        add(0, 3'b011, 3'b000, 1, 0, 1, 1);
        // Reset with 3 outstanding, pointer back to 0, orphans
        add(1, 3'b111, 3'b000, 1, 1, -1, 0);
        add(0, 3'b110, 3'b000, 1, 0, 1, 1);
        add(0, 3'b000, 3'b000, 1, 1, -1, 0);
        add(0, 3'b000, 3'b000, 1, 1, -1, 0);
        add(0, 3'b000, 3'b000, 1, 0, -1, 0);
        add(0, 3'b001, 3'b000, 1, 0, 0, 1);
        add(1, 3'b000, 3'b000, 1, 0, -1, 0);
        add(0, 3'b001, 3'b000, 1, 1, 0, 1);
        add(0, 3'b000, 3'b000, 1, 0, -1, 0);
        add(0, 3'b000, 3'b000, 1, 1, -1, 0);

        // Reset prologue: outputs forced low while rst is high
        @(negedge clk);
        drive(1'b1, 3'b111, 3'b000, 1'b1, 1'b1);
        #1;
        chk("rst req_ready", 512'(bus.req_ready), 512'(3'b000));
        chk("rst mem_req_valid", 512'(bus.mem_req_valid), 512'(1'b0));
        chk("rst resp_valid", 512'(bus.resp_valid), 512'(3'b000));
        exp_orphan = 1'b0;

        for (int n = 0; n < vecs.size(); n++) begin
            v = vecs[n];
            @(negedge clk);
            drive(v.rst, v.valid, v.lock, v.mrdy, v.mresp);
            #1;
            exp_rdy  = (!v.rst && v.mval && v.mrdy && v.gnt >= 0) ? (3'b001 << v.gnt) : 3'b000;
            exp_resp = (!v.rst && v.mresp && exp_q.size() > 0) ? (3'b001 << exp_q[0]) : 3'b000;
            chk($sformatf("row%0d req_ready", n), 512'(bus.req_ready), 512'(exp_rdy));
            chk($sformatf("row%0d mem_req_valid", n), 512'(bus.mem_req_valid), 512'(v.mval));
            chk($sformatf("row%0d resp_valid", n), 512'(bus.resp_valid), 512'(exp_resp));
            chk($sformatf("row%0d orphan_resp", n), 512'(orphan_resp), 512'(exp_orphan));
            if (!v.rst) begin
                exp_addr  = (v.gnt >= 0) ? addr_tab[v.gnt]  : '0;
                exp_wdata = (v.gnt >= 0) ? wdata_tab[v.gnt] : '0;
                exp_wstrb = (v.gnt >= 0) ? wstrb_tab[v.gnt] : '0;
                exp_write = (v.gnt >= 0) ? ((wr_tab >> v.gnt) & 3'b001) != 3'b000 : 1'b0;
                chk($sformatf("row%0d mem_req_addr", n), 512'(bus.mem_req_addr), 512'(exp_addr));
                chk($sformatf("row%0d mem_req_write", n), 512'(bus.mem_req_write), 512'(exp_write));
                chk($sformatf("row%0d mem_req_wdata", n), bus.mem_req_wdata, exp_wdata);
                chk($sformatf("row%0d mem_req_wstrb", n), 512'(bus.mem_req_wstrb), 512'(exp_wstrb));
                chk($sformatf("row%0d resp_rdata", n), bus.resp_rdata, bus.mem_resp_rdata);
            end
            if (v.rst) begin
                exp_q.delete();
                exp_orphan = 1'b0;
            end else begin
                if (v.mresp) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    else exp_orphan = 1'b1;
                end
                if (v.mval && v.mrdy && v.gnt >= 0) exp_q.push_back(v.gnt);
            end
        end

        // Orphan flag stays set through idle cycles and clears only on reset
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b0, 3'b000, 3'b000, 1'b1, 1'b0);
            #1;
            chk($sformatf("idle%0d orphan sticky", i), 512'(orphan_resp), 512'(1'b1));
        end
        @(negedge clk);
        drive(1'b1, 3'b000, 3'b000, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 3'b000, 3'b000, 1'b1, 1'b0);
        #1;
        chk("orphan after rst", 512'(orphan_resp), 512'(1'b0));
        chk("mem_req_valid idle after rst", 512'(bus.mem_req_valid), 512'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
